// File: rtl/bp_fe_btb_update_queue_if.sv
// BTB write-request channel between the update queue and the BTB write port.
// The queue side (master) presents the head entry; the BTB side (slave)
// consumes it with w_yumi.
interface bp_fe_btb_update_queue_if #(
    parameter int vaddr_width_p   = 39,
    parameter int btb_tag_width_p = 10,
    parameter int btb_idx_width_p = 6
);
    logic                       w_v;
    logic                       w_clr;
    logic                       w_jmp;
    logic [btb_tag_width_p-1:0] w_tag;
    logic [btb_idx_width_p-1:0] w_idx;
    logic [vaddr_width_p-1:0]   br_tgt;
    logic                       w_yumi;

    modport master (
        output w_v, w_clr, w_jmp, w_tag, w_idx, br_tgt,
        input  w_yumi
    );

    modport slave (
        input  w_v, w_clr, w_jmp, w_tag, w_idx, br_tgt,
        output w_yumi
    );
endinterface

// File: rtl/bp_fe_btb_update_queue.sv
// Branch-resolution update queue feeding the front-end BTB write port.
// Splits the branch-site PC into BTB idx/tag, holds writes until the BTB has
// finished initializing, and folds a newer update into any pending non-head
// entry with the same idx so an older target can never land after a newer one.
module bp_fe_btb_update_queue #(
    parameter int vaddr_width_p   = 39,
    parameter int btb_tag_width_p = 10,
    parameter int btb_idx_width_p = 6,
    parameter int els_p           = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         btb_init_done_i,
    input  logic                         flush_i,

    input  logic                         upd_v_i,
    output logic                         upd_ready_o,
    input  logic                         upd_clr_i,
    input  logic                         upd_jmp_i,
    input  logic [vaddr_width_p-1:0]     upd_src_addr_i,
    input  logic [vaddr_width_p-1:0]     upd_tgt_i,

    bp_fe_btb_update_queue_if.master     w,

    output logic [$clog2(els_p+1)-1:0]   count_o
);

    localparam int ptr_w    = $clog2(els_p);
    localparam int cnt_w    = $clog2(els_p+1);
    localparam int tag_lsb  = 2 + btb_idx_width_p;
    localparam int used_msb = tag_lsb + btb_tag_width_p;

    // Entry storage, one array per field, indexed by slot.
    logic                       clr_r [els_p];
    logic                       jmp_r [els_p];
    logic [btb_tag_width_p-1:0] tag_r [els_p];
    logic [btb_idx_width_p-1:0] idx_r [els_p];
    logic [vaddr_width_p-1:0]   tgt_r [els_p];

    logic [ptr_w-1:0] head_r;
    logic [ptr_w-1:0] tail_r;
    logic [cnt_w-1:0] count_r;

    logic [btb_idx_width_p-1:0] upd_idx;
    logic [btb_tag_width_p-1:0] upd_tag;

    logic             accept;
    logic             pop;
    logic             push;
    logic             merge_hit;
    logic [ptr_w-1:0] merge_slot;
    logic [ptr_w-1:0] cand;
    logic [ptr_w-1:0] wr_slot;

    assign upd_idx = upd_src_addr_i[2 +: btb_idx_width_p];
    assign upd_tag = upd_src_addr_i[tag_lsb +: btb_tag_width_p];

    // The byte-offset bits and anything above the tag never reach the BTB.
    if (vaddr_width_p > used_msb) begin : g_unused_hi
        logic unused_addr_bits;
        assign unused_addr_bits = ^{upd_src_addr_i[1:0],
                                    upd_src_addr_i[vaddr_width_p-1:used_msb]};
    end else begin : g_unused_lo
        logic unused_addr_bits;
        assign unused_addr_bits = ^upd_src_addr_i[1:0];
    end

    // Ready is purely a function of occupancy and flush so it can never
    // combinationally depend on the incoming update.
    assign upd_ready_o = (count_r < cnt_w'(els_p)) & ~flush_i;
    assign accept      = upd_v_i & upd_ready_o;
    assign pop         = w.w_yumi & w.w_v;
    assign push        = accept & ~merge_hit;
    assign wr_slot     = merge_hit ? merge_slot : tail_r;

    // Look for a pending non-head entry with the incoming idx; the head is
    // skipped so data already presented to the BTB never changes underneath it.
    always_comb begin
        merge_hit  = 1'b0;
        merge_slot = '0;
        cand       = '0;
        for (int i = 1; i < els_p; i++) begin
            cand = head_r + ptr_w'(i);
            if (!merge_hit && (cnt_w'(i) < count_r) && (idx_r[cand] == upd_idx)) begin
                merge_hit  = 1'b1;
                merge_slot = cand;
            end
        end
    end

    // Write accepted updates into either the merge slot or the tail slot.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            clr_r[wr_slot] <= upd_clr_i;
            jmp_r[wr_slot] <= upd_jmp_i;
            tag_r[wr_slot] <= upd_tag;
            idx_r[wr_slot] <= upd_idx;
            tgt_r[wr_slot] <= upd_tgt_i;
        end
    end

    // Pointer and occupancy bookkeeping; flush wins over any enqueue or pop.
    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (push) begin
                tail_r <= tail_r + ptr_w'(1);
            end
            if (pop) begin
                head_r <= head_r + ptr_w'(1);
            end
            count_r <= count_r + cnt_w'(push) - cnt_w'(pop);
        end
    end

    assign w.w_v    = btb_init_done_i & (count_r != '0);
    assign w.w_clr  = clr_r[head_r];
    assign w.w_jmp  = jmp_r[head_r];
    assign w.w_tag  = tag_r[head_r];
    assign w.w_idx  = idx_r[head_r];
    assign w.br_tgt = tgt_r[head_r];
    assign count_o  = count_r;

    // The BTB may only consume a write that is actually being offered.
    a_yumi_needs_valid: assert property (
        @(posedge clk_i) disable iff (reset_i) w.w_yumi |-> w.w_v
    );

endmodule

// File: tb/tb_bp_fe_btb_update_queue.sv
// Directed bench for the BTB update queue: issue order, init hold-off,
// merging, head protection, full-queue behavior with pointer wrap, flush
// and reset.
module tb_bp_fe_btb_update_queue;

    localparam int VA  = 39;
    localparam int TW  = 10;
    localparam int IW  = 6;
    localparam int ELS = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          init_done;
    logic          flush;
    logic          upd_v;
    logic          upd_ready;
    logic          upd_clr;
    logic          upd_jmp;
    logic [VA-1:0] upd_addr;
    logic [VA-1:0] upd_tgt;
    logic [2:0]    count;

    int total = 0;
    int bad   = 0;

    bp_fe_btb_update_queue_if #(
        .vaddr_width_p(VA), .btb_tag_width_p(TW), .btb_idx_width_p(IW)
    ) wif ();

    bp_fe_btb_update_queue #(
        .vaddr_width_p(VA), .btb_tag_width_p(TW), .btb_idx_width_p(IW), .els_p(ELS)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .btb_init_done_i(init_done),
        .flush_i        (flush),
        .upd_v_i        (upd_v),
        .upd_ready_o    (upd_ready),
        .upd_clr_i      (upd_clr),
        .upd_jmp_i      (upd_jmp),
        .upd_src_addr_i (upd_addr),
        .upd_tgt_i      (upd_tgt),
        .w              (wif.master),
        .count_o        (count)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    function automatic logic [VA-1:0] mk_addr(input int tag, input int idx);
        return (VA'(tag) << (2 + IW)) | (VA'(idx) << 2);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic clr, input logic jmp, input int tag, input int idx,
                       input logic [VA-1:0] tgt);
        upd_v    = 1'b1;
        upd_clr  = clr;
        upd_jmp  = jmp;
        upd_addr = mk_addr(tag, idx);
        upd_tgt  = tgt;
        step();
        upd_v   = 1'b0;
        upd_clr = 1'b0;
        upd_jmp = 1'b0;
    endtask

    task automatic yumi_cycle();
        wif.w_yumi = 1'b1;
        step();
        wif.w_yumi = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; init_done = 1'b1; flush = 1'b0; upd_v = 1'b0;
        upd_clr = 1'b0; upd_jmp = 1'b0; upd_addr = '0; upd_tgt = '0; wif.w_yumi = 1'b0;
        step(); step();
        reset = 1'b0;
        #1;
        total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
        total++; if (wif.w_v !== 1'b0) begin bad++; $display("[TB] FAIL reset_wv: got %0b want 0", wif.w_v); end
        total++; if (upd_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %0b want 1", upd_ready); end
    endtask

    task automatic test_basic();
        init_done = 1'b1;
        upd_v = 1'b1; upd_addr = VA'(64'h1004); upd_tgt = VA'(64'h2000); upd_jmp = 1'b0; upd_clr = 1'b0;
        #1;
        total++; if (wif.w_v !== 1'b0) begin bad++; $display("[TB] FAIL basic_no_bypass: got %0b want 0", wif.w_v); end
        step();
        upd_v = 1'b0;
        total++; if (wif.w_v !== 1'b1) begin bad++; $display("[TB] FAIL basic_wv: got %0b want 1", wif.w_v); end
        total++; if (wif.w_idx !== 6'h01) begin bad++; $display("[TB] FAIL basic_idx: got %h want 01", wif.w_idx); end
        total++; if (wif.w_tag !== 10'h010) begin bad++; $display("[TB] FAIL basic_tag: got %h want 010", wif.w_tag); end
        total++; if (wif.br_tgt !== VA'(64'h2000)) begin bad++; $display("[TB] FAIL basic_tgt: got %h want 2000", wif.br_tgt); end
        total++; if (wif.w_jmp !== 1'b0 || wif.w_clr !== 1'b0) begin bad++; $display("[TB] FAIL basic_flags: got jmp=%0b clr=%0b want 0 0", wif.w_jmp, wif.w_clr); end
        total++; if (count !== 3'd1) begin bad++; $display("[TB] FAIL basic_count: got %0d want 1", count); end
        yumi_cycle();
        total++; if (count !== 3'd0 || wif.w_v !== 1'b0) begin bad++; $display("[TB] FAIL basic_pop: got count=%0d wv=%0b want 0 0", count, wif.w_v); end
    endtask

    task automatic test_init_hold();
        init_done = 1'b0;
        for (int k = 0; k < 4; k++) enq(1'b0, 1'b1, 1, 4 + k, VA'(32'h100 + k));
        total++; if (wif.w_v !== 1'b0) begin bad++; $display("[TB] FAIL hold_wv: got %0b want 0", wif.w_v); end
        total++; if (count !== 3'd4) begin bad++; $display("[TB] FAIL hold_count: got %0d want 4", count); end
        total++; if (upd_ready !== 1'b0) begin bad++; $display("[TB] FAIL hold_ready: got %0b want 0", upd_ready); end
        init_done = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            total++; if (wif.w_v !== 1'b1 || wif.w_idx !== IW'(4 + k) || wif.br_tgt !== VA'(32'h100 + k) || wif.w_jmp !== 1'b1) begin
                bad++; $display("[TB] FAIL hold_order%0d: got v=%0b idx=%0d tgt=%h want 1 %0d %h", k, wif.w_v, wif.w_idx, wif.br_tgt, 4 + k, 32'h100 + k);
            end
            if (wif.w_v === 1'b1) yumi_cycle();
        end
        total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL hold_drain: got %0d want 0", count); end
    endtask

    task automatic test_merge();
        init_done = 1'b0;
        enq(1'b0, 1'b0, 2, 1, VA'(32'hA));
        enq(1'b0, 1'b0, 2, 2, VA'(32'hB));
        enq(1'b0, 1'b0, 3, 2, VA'(32'hC));
        total++; if (count !== 3'd2) begin bad++; $display("[TB] FAIL merge_count: got %0d want 2", count); end
        init_done = 1'b1;
        #1;
        total++; if (wif.w_idx !== 6'd1 || wif.br_tgt !== VA'(32'hA)) begin bad++; $display("[TB] FAIL merge_first: got idx=%0d tgt=%h want 1 a", wif.w_idx, wif.br_tgt); end
        yumi_cycle();
        total++; if (wif.w_idx !== 6'd2 || wif.br_tgt !== VA'(32'hC) || wif.w_tag !== 10'd3) begin
            bad++; $display("[TB] FAIL merge_second: got idx=%0d tgt=%h tag=%0d want 2 c 3", wif.w_idx, wif.br_tgt, wif.w_tag);
        end
        yumi_cycle();
        total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL merge_drain: got %0d want 0", count); end
    endtask

    task automatic test_head_protect();
        init_done = 1'b1;
        enq(1'b0, 1'b0, 5, 3, VA'(32'h30));
        total++; if (wif.w_v !== 1'b1 || wif.w_idx !== 6'd3) begin bad++; $display("[TB] FAIL head_present: got v=%0b idx=%0d want 1 3", wif.w_v, wif.w_idx); end
        enq(1'b1, 1'b0, 6, 3, VA'(32'h31));
        total++; if (count !== 3'd2) begin bad++; $display("[TB] FAIL head_count: got %0d want 2", count); end
        total++; if (wif.w_clr !== 1'b0 || wif.br_tgt !== VA'(32'h30) || wif.w_tag !== 10'd5) begin
            bad++; $display("[TB] FAIL head_stable: got clr=%0b tgt=%h tag=%0d want 0 30 5", wif.w_clr, wif.br_tgt, wif.w_tag);
        end
        yumi_cycle();
        total++; if (wif.w_idx !== 6'd3 || wif.w_clr !== 1'b1 || wif.br_tgt !== VA'(32'h31) || wif.w_tag !== 10'd6 || count !== 3'd1) begin
            bad++; $display("[TB] FAIL head_next: got idx=%0d clr=%0b tgt=%h tag=%0d cnt=%0d want 3 1 31 6 1", wif.w_idx, wif.w_clr, wif.br_tgt, wif.w_tag, count);
        end
        yumi_cycle();
    endtask

    task automatic test_merge_on_pop();
        init_done = 1'b1;
        enq(1'b0, 1'b0, 1, 8, VA'(32'h80));
        enq(1'b0, 1'b0, 1, 9, VA'(32'h90));
        wif.w_yumi = 1'b1;
        upd_v = 1'b1; upd_clr = 1'b0; upd_jmp = 1'b1; upd_addr = mk_addr(7, 9); upd_tgt = VA'(32'h99);
        step();
        wif.w_yumi = 1'b0; upd_v = 1'b0; upd_jmp = 1'b0;
        total++; if (count !== 3'd1 || wif.w_idx !== 6'd9 || wif.br_tgt !== VA'(32'h99) || wif.w_tag !== 10'd7 || wif.w_jmp !== 1'b1) begin
            bad++; $display("[TB] FAIL pop_merge: got cnt=%0d idx=%0d tgt=%h tag=%0d jmp=%0b want 1 9 99 7 1", count, wif.w_idx, wif.br_tgt, wif.w_tag, wif.w_jmp);
        end
        yumi_cycle();
    endtask

    task automatic test_full_and_wrap();
        int q[$];
        init_done = 1'b1;
        for (int k = 10; k < 14; k++) enq(1'b0, 1'b0, k, k, VA'(32'h300 + k));
        total++; if (count !== 3'd4 || upd_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_state: got cnt=%0d ready=%0b want 4 0", count, upd_ready); end
        wif.w_yumi = 1'b1;
        upd_v = 1'b1; upd_addr = mk_addr(14, 14); upd_tgt = VA'(32'h300 + 14);
        #1;
        total++; if (upd_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_pop_ready: got %0b want 0", upd_ready); end
        step();
        wif.w_yumi = 1'b0; upd_v = 1'b0;
        total++; if (count !== 3'd3 || wif.w_idx !== 6'd11) begin bad++; $display("[TB] FAIL full_after_pop: got cnt=%0d idx=%0d want 3 11", count, wif.w_idx); end
        enq(1'b0, 1'b0, 14, 14, VA'(32'h300 + 14));
        total++; if (count !== 3'd4) begin bad++; $display("[TB] FAIL full_refill: got %0d want 4", count); end
        q = '{11, 12, 13, 14};
        for (int n = 0; n < 14; n++) begin
            total++; if (wif.w_v !== 1'b1 || wif.w_idx !== IW'(q[0]) || wif.br_tgt !== VA'(32'h300 + q[0])) begin
                bad++; $display("[TB] FAIL wrap_order%0d: got v=%0b idx=%0d tgt=%h want 1 %0d %h", n, wif.w_v, wif.w_idx, wif.br_tgt, q[0], 32'h300 + q[0]);
            end
            if (wif.w_v === 1'b1) yumi_cycle();
            void'(q.pop_front());
            enq(1'b0, 1'b0, n + 1, 20 + n, VA'(32'h300 + 20 + n));
            q.push_back(20 + n);
        end
        while (q.size() > 0) begin
            total++; if (wif.w_v !== 1'b1 || wif.w_idx !== IW'(q[0])) begin
                bad++; $display("[TB] FAIL wrap_drain: got v=%0b idx=%0d want 1 %0d", wif.w_v, wif.w_idx, q[0]);
            end
            if (wif.w_v === 1'b1) yumi_cycle();
            void'(q.pop_front());
        end
        total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL wrap_empty: got %0d want 0", count); end
    endtask

    task automatic test_flush_and_reset();
        init_done = 1'b0;
        for (int k = 40; k < 43; k++) enq(1'b0, 1'b0, 1, k, VA'(k));
        flush = 1'b1;
        upd_v = 1'b1; upd_addr = mk_addr(1, 43); upd_tgt = VA'(43);
        #1;
        total++; if (upd_ready !== 1'b0) begin bad++; $display("[TB] FAIL flush_ready: got %0b want 0", upd_ready); end
        step();
        flush = 1'b0; upd_v = 1'b0; init_done = 1'b1;
        #1;
        total++; if (count !== 3'd0 || wif.w_v !== 1'b0) begin bad++; $display("[TB] FAIL flush_empty: got cnt=%0d wv=%0b want 0 0", count, wif.w_v); end
        enq(1'b0, 1'b0, 2, 44, VA'(44));
        total++; if (count !== 3'd1 || wif.w_idx !== 6'd44 || wif.br_tgt !== VA'(44)) begin
            bad++; $display("[TB] FAIL flush_reuse: got cnt=%0d idx=%0d tgt=%h want 1 44 2c", count, wif.w_idx, wif.br_tgt);
        end
        yumi_cycle();
        init_done = 1'b0;
        for (int k = 45; k < 48; k++) enq(1'b0, 1'b0, 1, k, VA'(k));
        reset = 1'b1; init_done = 1'b1;
        upd_v = 1'b1; upd_addr = mk_addr(1, 48); upd_tgt = VA'(48);
        step();
        reset = 1'b0; upd_v = 1'b0;
        #1;
        total++; if (count !== 3'd0 || wif.w_v !== 1'b0 || upd_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL reset_mid: got cnt=%0d wv=%0b ready=%0b want 0 0 1", count, wif.w_v, upd_ready);
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_basic();
        test_init_hold();
        test_merge();
        test_head_protect();
        test_merge_on_pop();
        test_full_and_wrap();
        test_flush_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
